// File: rtl/fixed_to_float_pipe.sv
// Fixed-point (INT_WID.FRA_WID) to IEEE-754 converter: an input register followed by
// five processing stages (sign/magnitude, leading one, normalise, round prep, round/pack).
module fixed_to_float_pipe #(
   parameter string FLOAT_FMT = "float",
   parameter int    INT_WID   = 16,
   parameter int    FRA_WID   = 16,
   parameter int    SIGNED_IN = 1,
   parameter int    TAG_WID   = 4
) (
   input  logic                                            clk,
   input  logic                                            rstn,
   input  logic                                            flush,
   input  logic                                            in_valid,
   output logic                                            in_ready,
   input  logic [INT_WID-1:0]                              in_int,
   input  logic [FRA_WID-1:0]                              in_frac,
   input  logic [1:0]                                      in_rnd,
   input  logic [TAG_WID-1:0]                              in_tag,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic [((FLOAT_FMT == "double") ? 64 : 32)-1:0]  out_float,
   output logic                                            out_inexact,
   output logic                                            out_zero,
   output logic [TAG_WID-1:0]                              out_tag
);

   localparam bit DBL       = (FLOAT_FMT == "double");
   localparam int FLOAT_WID = DBL ? 64 : 32;
   localparam int EXP_WID   = DBL ? 11 : 8;
   localparam int MANT_WID  = DBL ? 52 : 23;
   localparam int BIAS      = DBL ? 1023 : 127;
   localparam int W         = INT_WID + FRA_WID;
   localparam int PW        = $clog2(W);
   localparam int XW        = W + MANT_WID;
   localparam int EOFF      = BIAS - FRA_WID;

   logic                 stall;
   logic [5:0]           v_d, v_q;
   logic [1:0]           rnd_d [0:4];
   logic [1:0]           rnd_q [0:4];
   logic [TAG_WID-1:0]   tag_d [0:5];
   logic [TAG_WID-1:0]   tag_q [0:5];
   logic [4:1]           sign_d, sign_q;
   logic [W-1:0]         raw_d, raw_q;
   logic [W-1:0]         mag1_d, mag1_q, mag2_d, mag2_q;
   logic [PW-1:0]        p2_d, p2_q;
   logic [W-1:0]         norm3_d, norm3_q;
   logic [EXP_WID-1:0]   exp3_d, exp3_q, exp4_d, exp4_q;
   logic [MANT_WID-1:0]  mant4_d, mant4_q;
   logic                 guard4_d, guard4_q, sticky4_d, sticky4_q, zero4_d, zero4_q;
   logic [FLOAT_WID-1:0] float_d, float_q;
   logic                 inexact_d, inexact_q, zero5_d, zero5_q;

   logic [PW-1:0]        lead, shamt;
   logic [XW-1:0]        ext;
   logic                 inc;
   logic [MANT_WID:0]    mant_sum;
   logic [EXP_WID-1:0]   exp_rnd;

   assign stall       = v_q[5] & ~out_ready;
   assign in_ready    = ~stall;
   assign out_valid   = v_q[5];
   assign out_float   = float_q;
   assign out_inexact = inexact_q;
   assign out_zero    = zero5_q;
   assign out_tag     = tag_q[5];

   always_comb begin
      lead = '0;
      for (int i = 0; i < W; i++)
         if (mag1_q[i]) lead = PW'(i);
      shamt = PW'(W - 1) - p2_q;
      // Hidden bit dropped; zero padding guarantees guard/sticky exist for narrow inputs.
      ext   = {norm3_q[W-2:0], {(MANT_WID+1){1'b0}}};
      unique case (rnd_q[4])
         2'b00:   inc = guard4_q & (sticky4_q | mant4_q[0]);
         2'b01:   inc = 1'b0;
         2'b10:   inc = (guard4_q | sticky4_q) & ~sign_q[4];
         default: inc = (guard4_q | sticky4_q) & sign_q[4];
      endcase
      mant_sum = {1'b0, mant4_q} + (MANT_WID+1)'(inc);
      exp_rnd  = exp4_q + EXP_WID'(mant_sum[MANT_WID]);
   end

   always_comb begin
      v_d       = v_q;
      rnd_d     = rnd_q;
      tag_d     = tag_q;
      sign_d    = sign_q;
      raw_d     = raw_q;
      mag1_d    = mag1_q;
      mag2_d    = mag2_q;
      p2_d      = p2_q;
      norm3_d   = norm3_q;
      exp3_d    = exp3_q;
      exp4_d    = exp4_q;
      mant4_d   = mant4_q;
      guard4_d  = guard4_q;
      sticky4_d = sticky4_q;
      zero4_d   = zero4_q;
      float_d   = float_q;
      inexact_d = inexact_q;
      zero5_d   = zero5_q;
      if (!stall) begin
         v_d      = {v_q[4:0], in_valid};
         raw_d    = {in_int, in_frac};
         rnd_d[0] = in_rnd;
         tag_d[0] = in_tag;
         for (int k = 1; k < 5; k++) rnd_d[k] = rnd_q[k-1];
         for (int k = 1; k < 6; k++) tag_d[k] = tag_q[k-1];
         // Negating the most negative value wraps back to 2^(W-1), which is the right magnitude.
         sign_d[1]   = (SIGNED_IN != 0) && raw_q[W-1];
         mag1_d      = sign_d[1] ? -raw_q : raw_q;
         sign_d[4:2] = sign_q[3:1];
         p2_d        = lead;
         mag2_d      = mag1_q;
         norm3_d     = mag2_q << shamt;
         exp3_d      = EXP_WID'(EOFF) + EXP_WID'(p2_q);
         mant4_d     = ext[XW-1 -: MANT_WID];
         guard4_d    = ext[W-1];
         sticky4_d   = |ext[W-2:0];
         zero4_d     = ~norm3_q[W-1];
         exp4_d      = exp3_q;
         float_d     = zero4_q ? '0 : {sign_q[4], exp_rnd, mant_sum[MANT_WID-1:0]};
         inexact_d   = guard4_q | sticky4_q;
         zero5_d     = zero4_q;
      end
      if (flush) v_d = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v_q       <= '0;
         for (int k = 0; k < 5; k++) rnd_q[k] <= '0;
         for (int k = 0; k < 6; k++) tag_q[k] <= '0;
         sign_q    <= '0;
         raw_q     <= '0;
         mag1_q    <= '0;
         mag2_q    <= '0;
         p2_q      <= '0;
         norm3_q   <= '0;
         exp3_q    <= '0;
         exp4_q    <= '0;
         mant4_q   <= '0;
         guard4_q  <= 1'b0;
         sticky4_q <= 1'b0;
         zero4_q   <= 1'b0;
         float_q   <= '0;
         inexact_q <= 1'b0;
         zero5_q   <= 1'b0;
      end else begin
         v_q       <= v_d;
         rnd_q     <= rnd_d;
         tag_q     <= tag_d;
         sign_q    <= sign_d;
         raw_q     <= raw_d;
         mag1_q    <= mag1_d;
         mag2_q    <= mag2_d;
         p2_q      <= p2_d;
         norm3_q   <= norm3_d;
         exp3_q    <= exp3_d;
         exp4_q    <= exp4_d;
         mant4_q   <= mant4_d;
         guard4_q  <= guard4_d;
         sticky4_q <= sticky4_d;
         zero4_q   <= zero4_d;
         float_q   <= float_d;
         inexact_q <= inexact_d;
         zero5_q   <= zero5_d;
      end
   end

endmodule
